// File: rtl/sauria_pkg.sv
// Shared SAURIA parameters and types.
// - OC_W    : partial-sum element width
// - SRAMC_W : SRAM C data width
// - SRAMC_N : psums packed into one SRAM C word
// - ADRC_W  : SRAM C address width
// - psum_packer_state_t : psum packer FSM states (visible to benches for probing)
package sauria_pkg;

  localparam int OC_W    = 32;
  localparam int SRAMC_W = 128;
  localparam int SRAMC_N = SRAMC_W / OC_W;
  localparam int ADRC_W  = 12;

  typedef enum logic [1:0] {
    PP_IDLE  = 2'd0,
    PP_FILL  = 2'd1,
    PP_WRITE = 2'd2,
    PP_DONE  = 2'd3
  } psum_packer_state_t;

endpackage

// File: rtl/sauria_psum_packer.sv
// Packs SRAMC_N consecutive OC_W partial sums into one SRAMC_W word and
// writes each word to SRAM C at an auto-incrementing address through a
// request/grant port shared with the DMA.
//
// Ports:
// - i_clk, i_rstn              : clock, asynchronous active-low reset
// - i_start, i_base_addr,
//   i_num_words                : transfer command, accepted only when idle
// - i_abort                    : synchronous abort, drops any partial word
// - i_psum_valid, i_psum,
//   o_psum_ready               : psum input handshake
// - o_sram_req, i_sram_gnt,
//   o_sram_addr, o_sram_wdata  : SRAM C write port (held until grant)
// - o_busy                     : transfer in progress
// - o_done                     : one-cycle completion pulse
module sauria_psum_packer
  import sauria_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [ADRC_W-1:0]  i_base_addr,
  input  logic [ADRC_W-1:0]  i_num_words,
  input  logic               i_abort,
  input  logic               i_psum_valid,
  input  logic [OC_W-1:0]    i_psum,
  output logic               o_psum_ready,
  output logic               o_sram_req,
  input  logic               i_sram_gnt,
  output logic [ADRC_W-1:0]  o_sram_addr,
  output logic [SRAMC_W-1:0] o_sram_wdata,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IDX_W = (SRAMC_N > 1) ? $clog2(SRAMC_N) : 1;

  psum_packer_state_t state_q, state_d;
  logic [ADRC_W-1:0]  addr_q;
  logic [ADRC_W-1:0]  rem_q;
  logic [IDX_W-1:0]   idx_q;

  logic start_ok;
  logic accept;
  logic last_elem;
  logic grant;

  // Abort masks every event of its cycle: no start, no psum, no grant.
  assign start_ok  = (state_q == PP_IDLE) && i_start && !i_abort;
  assign accept    = o_psum_ready && i_psum_valid;
  assign last_elem = (idx_q == IDX_W'(SRAMC_N - 1));
  assign grant     = (state_q == PP_WRITE) && i_sram_gnt && !i_abort;

  // NOTE: state_d gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = PP_IDLE;
    end else begin
      case (state_q)
        PP_IDLE:  if (i_start) state_d = (i_num_words == '0) ? PP_DONE : PP_FILL;
        PP_FILL:  if (accept && last_elem) state_d = PP_WRITE;
        PP_WRITE: if (grant) state_d = (rem_q == ADRC_W'(1)) ? PP_DONE : PP_FILL;
        PP_DONE:  state_d = PP_IDLE;
        default:  state_d = PP_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= PP_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q <= i_base_addr;
        rem_q  <= i_num_words;
        idx_q  <= '0;
      end
      if (accept) begin
        idx_q <= last_elem ? '0 : idx_q + IDX_W'(1);
      end
      // Address wraps naturally at 2^ADRC_W.
      if (grant) begin
        addr_q <= addr_q + ADRC_W'(1);
        rem_q  <= rem_q - ADRC_W'(1);
      end
    end
  end

  // Pack register: one lane per element, lane k enabled when the index
  // points at it. Element 0 lands in the LSBs.
  for (genvar k = 0; k < SRAMC_N; k++) begin : g_lane
    logic [OC_W-1:0] lane_q;

    // NOTE: the pack lanes drive o_sram_wdata directly, so they are reset
    // to give a defined all-zero write bus out of reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        lane_q <= '0;
      end else if (accept && (idx_q == IDX_W'(k))) begin
        lane_q <= i_psum;
      end
    end

    assign o_sram_wdata[k*OC_W +: OC_W] = lane_q;
  end

  // Outputs decode registered state; only ready sees i_abort directly.
  assign o_psum_ready = (state_q == PP_FILL) && !i_abort;
  assign o_sram_req   = (state_q == PP_WRITE);
  assign o_sram_addr  = addr_q;
  assign o_busy       = (state_q != PP_IDLE);
  assign o_done       = (state_q == PP_DONE);

endmodule

// File: tb/tb_sauria_psum_packer.sv
// Self-checking bench for sauria_psum_packer. Expected SRAM writes are
// built from the psum streams the bench sends: word w goes to
// (base + w) mod 2^ADRC_W and holds psums 4w..4w+3, element 0 in the LSBs.
module tb_sauria_psum_packer;
  import sauria_pkg::*;

  logic               i_clk;
  logic               i_rstn;
  logic               i_start;
  logic [ADRC_W-1:0]  i_base_addr;
  logic [ADRC_W-1:0]  i_num_words;
  logic               i_abort;
  logic               i_psum_valid;
  logic [OC_W-1:0]    i_psum;
  logic               o_psum_ready;
  logic               o_sram_req;
  logic               i_sram_gnt;
  logic [ADRC_W-1:0]  o_sram_addr;
  logic [SRAMC_W-1:0] o_sram_wdata;
  logic               o_busy;
  logic               o_done;

  sauria_psum_packer dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_num_words  (i_num_words),
    .i_abort      (i_abort),
    .i_psum_valid (i_psum_valid),
    .i_psum       (i_psum),
    .o_psum_ready (o_psum_ready),
    .o_sram_req   (o_sram_req),
    .i_sram_gnt   (i_sram_gnt),
    .o_sram_addr  (o_sram_addr),
    .o_sram_wdata (o_sram_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  typedef struct {
    logic [ADRC_W-1:0]  addr;
    logic [SRAMC_W-1:0] data;
    int                 cyc;
  } wr_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  s_cyc    = 0;
  bit  gnt_auto = 1'b1;
  int  gnt_delay = 0;
  int  wait_cnt = 0;

  // Monitor results
  wr_t wr_q[$];
  int  done_cnt, done_cyc, req_cycles, ready_seen, ready_in_write, stab_viol;
  logic               prev_req, prev_gnt;
  logic [ADRC_W-1:0]  prev_addr;
  logic [SRAMC_W-1:0] prev_data;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc++;

  // Grant responder: grants after gnt_delay waiting cycles of a request.
  always @(posedge i_clk) begin
    #1;
    if (gnt_auto) begin
      if (o_sram_req) begin
        if (wait_cnt >= gnt_delay) begin
          i_sram_gnt = 1'b1;
          wait_cnt   = 0;
        end else begin
          i_sram_gnt = 1'b0;
          wait_cnt++;
        end
      end else begin
        i_sram_gnt = (gnt_delay == 0);
        wait_cnt   = 0;
      end
    end
  end

  // Mid-cycle monitor: logs completed writes and handshake properties.
  always @(negedge i_clk) begin
    if (i_rstn) begin
      if (o_sram_req) begin
        req_cycles++;
        if (prev_req && !prev_gnt &&
            (o_sram_addr !== prev_addr || o_sram_wdata !== prev_data))
          stab_viol++;
        if (o_psum_ready) ready_in_write++;
        if (i_sram_gnt && !i_abort) wr_q.push_back('{o_sram_addr, o_sram_wdata, cyc});
      end
      if (o_psum_ready) ready_seen++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_req  = o_sram_req;
      prev_gnt  = i_sram_gnt || i_abort;
      prev_addr = o_sram_addr;
      prev_data = o_sram_wdata;
    end else begin
      prev_req = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wr_q.delete();
    done_cnt = 0; done_cyc = -1; req_cycles = 0;
    ready_seen = 0; ready_in_write = 0; stab_viol = 0;
  endtask

  function automatic logic [SRAMC_W-1:0] exp_word(input logic [OC_W-1:0] q[$], input int w);
    logic [SRAMC_W-1:0] d;
    for (int k = 0; k < SRAMC_N; k++) d[k*OC_W +: OC_W] = q[w*SRAMC_N + k];
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after start.
  task automatic do_start(input logic [ADRC_W-1:0] base, input logic [ADRC_W-1:0] num);
    i_start = 1'b1; i_base_addr = base; i_num_words = num;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic feed(input logic [OC_W-1:0] q[$], input int first, input int last,
                      input bit rand_valid);
    int i = first;
    int budget = 400;
    bit acc;
    while (i <= last && budget > 0) begin
      i_psum_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_psum       = i_psum_valid ? q[i] : $urandom;
      @(negedge i_clk);
      acc = o_psum_ready && i_psum_valid;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (acc) i++;
      budget--;
    end
    i_psum_valid = 1'b0;
    n_checks++;
    if (i <= last) begin
      n_fail++;
      $display("FAIL feed_timeout: accepted up to %0d, required %0d", i - 1, last);
    end
  endtask

  task automatic wait_done(input int budget);
    int b = budget;
    while (done_cnt == 0 && b > 0) begin
      @(posedge i_clk); #1;
      b--;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL done_timeout: no o_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_words = '0;
    i_abort = 1'b0; i_psum_valid = 1'b0; i_psum = '0; i_sram_gnt = 1'b0;
    clear_mon();
    #1;
    n_checks++;
    if ({o_psum_ready, o_sram_req, o_busy, o_done, o_sram_addr, o_sram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b req=%b busy=%b done=%b addr=%h wdata=%h, required all 0",
               o_psum_ready, o_sram_req, o_busy, o_done, o_sram_addr, o_sram_wdata);
    end
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (dut.state_q !== PP_IDLE || dut.idx_q !== '0 || dut.rem_q !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d idx=%0d rem=%0d, required 0 0 0",
               dut.state_q, dut.idx_q, dut.rem_q);
    end
    n_checks++;
    if ({o_psum_ready, o_sram_req, o_busy, o_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle_outputs: got %b, required 0000",
               {o_psum_ready, o_sram_req, o_busy, o_done});
    end
  endtask

  task automatic test_basic();
    logic [OC_W-1:0] q[$];
    for (int i = 1; i <= 8; i++) q.push_back(OC_W'(i));
    clear_mon();
    gnt_delay = 0;
    do_start(12'h010, 12'd2);
    n_checks++;
    if (o_psum_ready !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_after_start: got rdy=%b busy=%b, required 1 1", o_psum_ready, o_busy);
    end
    feed(q, 0, 7, 1'b0);
    wait_done(50);
    n_checks++;
    if (wr_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d, required 2", wr_q.size());
    end
    for (int w = 0; w < 2 && w < wr_q.size(); w++) begin
      n_checks++;
      if (wr_q[w].addr !== 12'h010 + ADRC_W'(w) || wr_q[w].data !== exp_word(q, w)) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h@%h, required %h@%h", w, wr_q[w].data,
                 wr_q[w].addr, exp_word(q, w), 12'h010 + ADRC_W'(w));
      end
    end
    if (wr_q.size() == 2) begin
      n_checks++;
      if (wr_q[0].cyc != s_cyc + 4 || wr_q[1].cyc != s_cyc + 9 || done_cyc != wr_q[1].cyc + 1) begin
        n_fail++;
        $display("FAIL basic_timing: got req cycles %0d,%0d done %0d, required %0d,%0d done %0d",
                 wr_q[0].cyc - s_cyc, wr_q[1].cyc - s_cyc, done_cyc - s_cyc, 4, 9, 10);
      end
    end
    n_checks++;
    if (o_busy !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_end: got busy=%b done_pulses=%0d, required 0 1", o_busy, done_cnt);
    end
  endtask

  task automatic test_num_zero();
    clear_mon();
    do_start(12'h123, 12'd0);
    n_checks++;
    if (o_done !== 1'b1 || o_psum_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b rdy=%b, required 1 0", o_done, o_psum_ready);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: got done=%b busy=%b, required 0 0", o_done, o_busy);
    end
    repeat (3) begin @(posedge i_clk); #1; end
    n_checks++;
    if (req_cycles != 0 || ready_seen != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_activity: got req=%0d rdy=%0d done=%0d, required 0 0 1",
               req_cycles, ready_seen, done_cnt);
    end
  endtask

  task automatic test_wrap_delayed_gnt();
    logic [OC_W-1:0] q[$];
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    clear_mon();
    gnt_delay = 3;
    do_start(12'hFFF, 12'd2);
    feed(q, 0, 7, 1'b1);
    wait_done(100);
    n_checks++;
    if (wr_q.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_write_count: got %0d, required 2", wr_q.size());
    end
    for (int w = 0; w < 2 && w < wr_q.size(); w++) begin
      n_checks++;
      if (wr_q[w].addr !== 12'hFFF + ADRC_W'(w) || wr_q[w].data !== exp_word(q, w)) begin
        n_fail++;
        $display("FAIL wrap_write%0d: got %h@%h, required %h@%h", w, wr_q[w].data,
                 wr_q[w].addr, exp_word(q, w), 12'hFFF + ADRC_W'(w));
      end
    end
    n_checks++;
    if (stab_viol != 0 || ready_in_write != 0 || req_cycles != 8) begin
      n_fail++;
      $display("FAIL wrap_hold: got unstable=%0d rdy_in_write=%0d req_cycles=%0d, required 0 0 8",
               stab_viol, ready_in_write, req_cycles);
    end
    gnt_delay = 0;
  endtask

  task automatic test_abort_fill();
    logic [OC_W-1:0] q[$];
    logic [OC_W-1:0] q2[$];
    for (int i = 0; i < 4; i++) begin q.push_back($urandom); q2.push_back($urandom); end
    clear_mon();
    do_start(12'h030, 12'd1);
    feed(q, 0, 1, 1'b0);
    i_abort = 1'b1; i_psum_valid = 1'b1; i_psum = q[2];
    @(negedge i_clk);
    n_checks++;
    if (o_psum_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready_gate: got rdy=%b, required 0", o_psum_ready);
    end
    @(posedge i_clk); #1;
    i_abort = 1'b0; i_psum_valid = 1'b0;
    n_checks++;
    if (dut.state_q !== PP_IDLE || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got state=%0d busy=%b, required 0 0", dut.state_q, o_busy);
    end
    repeat (5) begin @(posedge i_clk); #1; end
    n_checks++;
    if (wr_q.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_write: got writes=%0d done=%0d, required 0 0", wr_q.size(), done_cnt);
    end
    clear_mon();
    do_start(12'h020, 12'd1);
    feed(q2, 0, 3, 1'b1);
    wait_done(50);
    n_checks++;
    if (wr_q.size() != 1) begin
      n_fail++;
      $display("FAIL restart_count: got %0d, required 1", wr_q.size());
    end else if (wr_q[0].addr !== 12'h020 || wr_q[0].data !== exp_word(q2, 0)) begin
      n_fail++;
      $display("FAIL restart_write: got %h@%h, required %h@020", wr_q[0].data, wr_q[0].addr,
               exp_word(q2, 0));
    end
  endtask

  task automatic test_async_reset();
    logic [OC_W-1:0] q[$];
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    clear_mon();
    gnt_auto = 1'b0; i_sram_gnt = 1'b0;
    do_start(12'h100, 12'd1);
    feed(q, 0, 3, 1'b0);
    repeat (2) begin @(posedge i_clk); #1; end
    n_checks++;
    if (o_sram_req !== 1'b1 || o_sram_addr !== 12'h100 || o_sram_wdata !== exp_word(q, 0)) begin
      n_fail++;
      $display("FAIL rst_pre_write: got req=%b %h@%h, required 1 %h@100", o_sram_req,
               o_sram_wdata, o_sram_addr, exp_word(q, 0));
    end
    #2 i_rstn = 1'b0;
    #1;
    n_checks++;
    if ({o_psum_ready, o_sram_req, o_busy, o_done, o_sram_addr, o_sram_wdata} !== '0 ||
        dut.state_q !== PP_IDLE) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b req=%b busy=%b done=%b addr=%h wdata=%h, required all 0",
               o_psum_ready, o_sram_req, o_busy, o_done, o_sram_addr, o_sram_wdata);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    gnt_auto = 1'b1;
    n_checks++;
    if (o_busy !== 1'b0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_after: got busy=%b writes=%0d, required 0 0", o_busy, wr_q.size());
    end
  endtask

  task automatic test_start_ignored();
    logic [OC_W-1:0] q[$];
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    clear_mon();
    do_start(12'h200, 12'd2);
    i_start = 1'b1; i_base_addr = 12'h555; i_num_words = 12'd7;
    feed(q, 0, 7, 1'b0);
    wait_done(50);
    n_checks++;
    if (wr_q.size() != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ign_count: got writes=%0d done=%0d, required 2 1", wr_q.size(), done_cnt);
    end
    for (int w = 0; w < 2 && w < wr_q.size(); w++) begin
      n_checks++;
      if (wr_q[w].addr !== 12'h200 + ADRC_W'(w) || wr_q[w].data !== exp_word(q, w)) begin
        n_fail++;
        $display("FAIL ign_write%0d: got %h@%h, required %h@%h", w, wr_q[w].data,
                 wr_q[w].addr, exp_word(q, w), 12'h200 + ADRC_W'(w));
      end
    end
  endtask

  task automatic test_abort_collide();
    logic [OC_W-1:0] q[$];
    logic [OC_W-1:0] q2[$];
    for (int i = 0; i < 4; i++) begin q.push_back($urandom); q2.push_back($urandom); end
    clear_mon();
    gnt_auto = 1'b0; i_sram_gnt = 1'b0;
    do_start(12'h040, 12'd2);
    feed(q, 0, 3, 1'b0);
    @(posedge i_clk); #1;
    i_sram_gnt = 1'b1; i_abort = 1'b1; i_psum_valid = 1'b1; i_psum = $urandom;
    @(posedge i_clk); #1;
    i_sram_gnt = 1'b0; i_abort = 1'b0; i_psum_valid = 1'b0;
    n_checks++;
    if (dut.state_q !== PP_IDLE || o_sram_addr !== 12'h040 || dut.rem_q !== 12'd2) begin
      n_fail++;
      $display("FAIL abort_gnt: got state=%0d addr=%h rem=%0d, required 0 040 2",
               dut.state_q, o_sram_addr, dut.rem_q);
    end
    // Abort while filling with a valid psum: lane 1 must keep q[1].
    do_start(12'h050, 12'd1);
    feed(q2, 0, 0, 1'b0);
    i_abort = 1'b1; i_psum_valid = 1'b1; i_psum = ~q[1];
    @(negedge i_clk);
    n_checks++;
    if (o_psum_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_fill_ready: got rdy=%b, required 0", o_psum_ready);
    end
    @(posedge i_clk); #1;
    i_abort = 1'b0; i_psum_valid = 1'b0;
    n_checks++;
    if (o_sram_wdata[OC_W +: OC_W] !== q[1] || o_sram_wdata[0 +: OC_W] !== q2[0]) begin
      n_fail++;
      $display("FAIL abort_fill_lanes: got lane1=%h lane0=%h, required %h %h",
               o_sram_wdata[OC_W +: OC_W], o_sram_wdata[0 +: OC_W], q[1], q2[0]);
    end
    repeat (4) begin @(posedge i_clk); #1; end
    n_checks++;
    if (done_cnt != 0 || wr_q.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_collide_quiet: got done=%0d writes=%0d busy=%b, required 0 0 0",
               done_cnt, wr_q.size(), o_busy);
    end
    gnt_auto = 1'b1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [OC_W-1:0]   q[$];
      logic [ADRC_W-1:0] base;
      int                num;
      base = (it % 2 == 1) ? 12'hFFE : ADRC_W'($urandom);
      num  = $urandom_range(1, 3);
      gnt_delay = $urandom_range(0, 2);
      for (int i = 0; i < num * SRAMC_N; i++) q.push_back($urandom);
      clear_mon();
      do_start(base, ADRC_W'(num));
      feed(q, 0, num * SRAMC_N - 1, 1'b1);
      wait_done(60);
      n_checks++;
      if (wr_q.size() != num || done_cnt != 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: got writes=%0d done=%0d, required %0d 1",
                 it, wr_q.size(), done_cnt, num);
      end
      for (int w = 0; w < num && w < wr_q.size(); w++) begin
        n_checks++;
        if (wr_q[w].addr !== base + ADRC_W'(w) || wr_q[w].data !== exp_word(q, w)) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %h@%h, required %h@%h", it, w, wr_q[w].data,
                   wr_q[w].addr, exp_word(q, w), base + ADRC_W'(w));
        end
      end
      @(posedge i_clk); #1;
    end
    gnt_delay = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_num_zero();
    test_wrap_delayed_gnt();
    test_abort_fill();
    test_async_reset();
    test_start_ignored();
    test_abort_collide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sauria_psum_packer.md
# sauria_psum_packer

Output-side stage between the systolic array's partial-sum shift-out and SRAM C. It accepts one OC_W psum per handshake and packs SRAMC_N consecutive psums into one SRAMC_W word. It writes each packed word to SRAM C at an auto-incrementing address through a request/grant port shared with the DMA. A start command fixes the base address and the number of words; a one-cycle done pulse closes the transfer.

## Interface
- OC_W, 32, psum element width
- SRAMC_W, 128, SRAM C data width
- SRAMC_N, SRAMC_W/OC_W (4), psums per SRAM word
- ADRC_W, 12, SRAM C address width

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rstn  in  1  asynchronous, active-low reset (single clock domain, async active-low reset: fixed)
- i_start  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  ADRC_W  first SRAM C word address, latched on accepted i_start
- i_num_words  in  ADRC_W  SRAM words to write, latched on accepted i_start
- i_abort  in  1  synchronous abort, any state
- i_psum_valid  in  1  psum available
- i_psum  in  OC_W  psum data
- o_psum_ready  out  1  packer accepts psum this cycle
- o_sram_req  out  1  write request to SRAM C arbiter
- i_sram_gnt  in  1  write performed this cycle
- o_sram_addr  out  ADRC_W  write address
- o_sram_wdata  out  SRAMC_W  packed write data
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, i_start=1:
  - latch base address into the address register and i_num_words into the remaining counter; clear the element index.
  - go to DONE if i_num_words==0, else go to FILL.
- FILL:
  - o_psum_ready=1; a psum is accepted when i_psum_valid && o_psum_ready.
  - element k (k=0..SRAMC_N-1) is written to o_sram_wdata[k*OC_W +: OC_W]; element 0 is LSBs.
  - on acceptance of element SRAMC_N-1: index returns to 0 and the state goes to WRITE.
- WRITE:
  - o_sram_req=1; o_psum_ready=0.
  - addr and wdata are held stable until i_sram_gnt.
  - on gnt: addr increments modulo 2^ADRC_W (wraps 0xFFF→0x000) and remaining decrements. Next state is DONE if remaining was 1, else FILL.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start outside IDLE: ignored, no effect.
- i_abort:
  - next state IDLE from any state; a partial word is discarded; no o_done.
  - abort has priority over gnt and psum acceptance in the same cycle: the cycle's gnt is not counted and the psum is not consumed (o_psum_ready forced 0 when i_abort=1).
- i_start and i_abort together in IDLE: abort wins, stay IDLE.
- i_psum_valid ignored outside FILL.
- o_sram_req must not depend combinationally on i_sram_gnt.

## Timing
- Reset values:
  - state=IDLE
  - o_psum_ready=0, o_sram_req=0, o_busy=0, o_done=0
  - o_sram_addr=0, o_sram_wdata=0
  - index=0, remaining=0
- All outputs are registered-state decodes; no input→output combinational path except o_psum_ready's gating by i_abort.
- i_start at edge t: FILL from t+1; o_psum_ready high in cycle t+1.
- The last psum of a word accepted at edge t gives o_sram_req high in cycle t+1.
- Best-case throughput: SRAMC_N+1 cycles per word (4 fill + 1 write, gnt held high).
- Last gnt at edge t: o_done high in cycle t+1, o_busy low from t+2.
- Asynchronous reset mid-transfer: outputs take reset values immediately; the transfer is lost.

## Structure
- Parameters come from the shared sauria_pkg (OC_W, SRAMC_W, SRAMC_N, ADRC_W); no new package constants.
- The FSM state enum goes in sauria_pkg as a typedef (psum_packer_state_t) so the bench can probe it.
- Single module, no sub-module; the pack register is SRAMC_N OC_W-wide lanes with per-lane enable from the index decode.

## Test plan
- Start base=0x010, num=2; psums 1..8 streamed with gnt tied 1 → writes 0x00000004_00000003_00000002_00000001 @0x010, then 0x...08_07_06_05 @0x011; o_done one cycle after second gnt.
- num=0 → o_done the cycle after start, no o_sram_req, o_psum_ready never high.
- Base=0xFFF, num=2, gnt delayed 3 cycles per word → addr/wdata stable while req high; addresses 0xFFF then 0x000; o_psum_ready low during WRITE.
- i_abort after 2 of 4 psums of word 1 → IDLE next cycle, no write, no done; new start with base=0x020 writes cleanly from element 0.
- Async i_rstn low during WRITE → all outputs 0 immediately; i_start during FILL ignored (address sequence unchanged).
- i_abort coinciding with i_sram_gnt and with psum valid → gnt not counted, psum not accepted, IDLE next cycle, o_done stays 0.
